// File: rtl/alu_issue_sequencer_if.sv
// Instruction-in and result-out handshake bundle for the bit-serial ALU issue sequencer.
// master = upstream/downstream side, slave = the sequencer.
interface alu_issue_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_opcode;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_c;
    logic [2:0] out_flags;
    logic [2:0] out_opcode;

    modport master (
        output in_valid, in_opcode, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_c, out_flags, out_opcode
    );

    modport slave (
        input  in_valid, in_opcode, in_a, in_b, out_ready,
        output in_ready, out_valid, out_c, out_flags, out_opcode
    );
endinterface

// File: rtl/alu_issue_sequencer.sv
// Feeds a free-running 4-phase bit-serial ALU from an instruction FIFO, aligning each
// operand load to ALU phase 0, then captures result/flags into a valid/ready output slot.
module alu_issue_sequencer #(
    parameter int         DEPTH         = 4,
    parameter int         OP_CYCLES     = 4,
    parameter int         CAPTURE_DELAY = 5,
    parameter logic [2:0] IDLE_OPCODE   = 3'b000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    alu_issue_sequencer_if.slave       io,
    output logic [2:0]                 alu_opcode,
    output logic [3:0]                 alu_a,
    output logic [3:0]                 alu_b,
    input  logic [3:0]                 alu_c,
    input  logic                       alu_carr,
    input  logic                       alu_sign,
    input  logic                       alu_zero,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = (OP_CYCLES > 1) ? $clog2(OP_CYCLES) : 1;
    localparam int EW = $clog2(CAPTURE_DELAY + 1);

    localparam logic [PW-1:0] PH_LAST     = PW'(OP_CYCLES - 1);
    localparam logic [PW-1:0] CAP_PH      = PW'((CAPTURE_DELAY - 1) % OP_CYCLES);
    localparam logic [EW-1:0] ELAPSED_MAX = EW'(CAPTURE_DELAY);
    localparam logic [CW-1:0] FULL        = CW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_RUN} state_t;

    typedef struct packed {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
    } instr_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ph;
    logic [EW-1:0]   elapsed, elapsed_inc;
    logic [AW-1:0]   wptr, rptr;
    instr_t          mem [DEPTH];
    logic            push, load, capture, cap_edge, slot_free;

    // in_ready depends only on the registered occupancy, never on in_valid
    assign io.in_ready = (count != FULL);
    assign push        = io.in_valid & io.in_ready;
    assign busy        = (state_q != S_IDLE) | (count != '0);

    assign elapsed_inc = (elapsed == ELAPSED_MAX) ? elapsed : elapsed + 1'b1;
    assign cap_edge    = (elapsed_inc >= ELAPSED_MAX) && (ph == CAP_PH);
    assign slot_free   = ~io.out_valid | io.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph      <= '0;
            state_q <= S_IDLE;
        end else begin
            ph      <= (ph == PH_LAST) ? '0 : ph + 1'b1;
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        capture = 1'b0;
        case (state_q)
            S_IDLE:  if (count != '0) state_d = S_ALIGN;
            S_ALIGN: if (ph == PH_LAST) begin
                         load    = 1'b1;
                         state_d = S_RUN;
                     end
            // A missed capture edge simply waits a full ALU cycle; the ALU recomputes the same result
            S_RUN:   if (cap_edge && slot_free) begin
                         capture = 1'b1;
                         state_d = (count != '0) ? S_ALIGN : S_IDLE;
                     end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (load) rptr <= rptr + 1'b1;
            case ({push, load})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= '{op: io.in_opcode, a: io.in_a, b: io.in_b};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_opcode <= IDLE_OPCODE;
            alu_a      <= '0;
            alu_b      <= '0;
            elapsed    <= '0;
        end else if (load) begin
            alu_opcode <= mem[rptr].op;
            alu_a      <= mem[rptr].a;
            alu_b      <= mem[rptr].b;
            elapsed    <= '0;
        end else if (capture) begin
            alu_opcode <= IDLE_OPCODE;
        end else if (state_q == S_RUN) begin
            elapsed    <= elapsed_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io.out_valid  <= 1'b0;
            io.out_c      <= '0;
            io.out_flags  <= '0;
            io.out_opcode <= '0;
        end else if (capture) begin
            io.out_valid  <= 1'b1;
            io.out_c      <= alu_c;
            io.out_flags  <= {alu_carr, alu_sign, alu_zero};
            io.out_opcode <= alu_opcode;
        end else if (io.out_valid && io.out_ready) begin
            io.out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Directed bench for alu_issue_sequencer with a bit-serial ALU model on the ALU side.
module tb_alu_issue_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] alu_opcode;
    logic [3:0] alu_a, alu_b;
    logic [3:0] alu_c;
    logic       alu_carr, alu_sign, alu_zero;
    logic       busy;
    logic [2:0] count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_cnt  = 0;
    int max_count = 0;

    alu_issue_sequencer_if io ();

    alu_issue_sequencer dut (
        .clk(clk), .rst_n(rst_n), .io(io),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_c(alu_c), .alu_carr(alu_carr), .alu_sign(alu_sign), .alu_zero(alu_zero),
        .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
    always @(negedge clk) if (int'(count) > max_count) max_count <= int'(count);

    // ALU model: op 000 clear, 001 xor, 010 and, 011 nand, 100 add, 101 sub, 110 or, 111 pass A
    function automatic logic [4:0] alu_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            3'b000:  return 5'd0;
            3'b001:  return {1'b0, a ^ b};
            3'b010:  return {1'b0, a & b};
            3'b011:  return {1'b0, ~(a & b)};
            3'b100:  return {1'b0, a} + {1'b0, b};
            3'b101:  return {1'b0, a} - {1'b0, b};
            3'b110:  return {1'b0, a | b};
            default: return {1'b0, a};
        endcase
    endfunction

    logic [1:0] tb_ph;
    logic [2:0] m_op;
    logic [3:0] m_a, m_b, m_acc;
    logic [2:0] s_op;
    logic [3:0] s_a, s_b;
    logic [4:0] s_res;
    assign s_op  = (tb_ph == 2'd0) ? alu_opcode : m_op;
    assign s_a   = (tb_ph == 2'd0) ? alu_a : m_a;
    assign s_b   = (tb_ph == 2'd0) ? alu_b : m_b;
    assign s_res = alu_fn(s_op, s_a, s_b);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tb_ph <= 2'd0; m_op <= 3'd0; m_a <= 4'd0; m_b <= 4'd0; m_acc <= 4'd0;
            alu_c <= 4'd0; alu_carr <= 1'b0; alu_sign <= 1'b0; alu_zero <= 1'b0;
        end else begin
            tb_ph <= tb_ph + 2'd1;
            if (tb_ph == 2'd0) begin
                m_op <= alu_opcode; m_a <= alu_a; m_b <= alu_b;
            end
            m_acc[tb_ph] <= s_res[tb_ph];
            if (tb_ph == 2'd3) begin
                alu_c    <= {s_res[3], m_acc[2:0]};
                alu_carr <= s_res[4];
                alu_sign <= s_res[3];
                alu_zero <= ({s_res[3], m_acc[2:0]} == 4'd0);
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Entered and left on a negedge; the push lands on the first edge with in_ready high.
    task automatic push(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        int n;
        n = 0;
        io.in_valid = 1'b1; io.in_opcode = op; io.in_a = a; io.in_b = b;
        while (!io.in_ready && n < 40) begin @(negedge clk); n++; end
        check_val("push_ready", 32'(io.in_ready), 32'd1);
        @(negedge clk);
        io.in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, input logic [3:0] ec, input logic [2:0] ef,
                            input logic [2:0] eo, output int seen);
        int n;
        n = 0;
        while (!io.out_valid && n < 40) begin @(negedge clk); n++; end
        seen = cyc_cnt;
        check_val({tag, "_valid"}, 32'(io.out_valid), 32'd1);
        check_val({tag, "_c"}, 32'(io.out_c), 32'(ec));
        check_val({tag, "_flags"}, 32'(io.out_flags), 32'(ef));
        check_val({tag, "_op"}, 32'(io.out_opcode), 32'(eo));
    endtask

    task automatic wait_idle(input logic [1:0] want_ph);
        int n;
        n = 0;
        while ((io.out_valid || busy || tb_ph != want_ph) && n < 60) begin @(negedge clk); n++; end
        check_val("idle_busy", 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [2:0] op;
        logic [3:0] a, b, c;
        logic [2:0] f;
    } vec_t;

    vec_t fill_v[5];
    int   t_push, t_seen, t_prev;
    logic ok;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        fill_v = '{'{3'b001, 4'h3, 4'h5, 4'h6, 3'b000},
                   '{3'b100, 4'h7, 4'h8, 4'hF, 3'b010},
                   '{3'b011, 4'hC, 4'hA, 4'h7, 3'b000},
                   '{3'b100, 4'hF, 4'h1, 4'h0, 3'b101},
                   '{3'b110, 4'h8, 4'h1, 4'h9, 3'b010}};
        rst_n = 1'b0;
        io.in_valid = 1'b0; io.in_opcode = 3'd0; io.in_a = 4'd0; io.in_b = 4'd0;
        io.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_val("rst_count", 32'(count), 32'd0);
        check_val("rst_in_ready", 32'(io.in_ready), 32'd1);
        check_val("rst_out_valid", 32'(io.out_valid), 32'd0);
        check_val("rst_alu_opcode", 32'(alu_opcode), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // Single XOR right after reset: load on edge 4 (ph 3), capture on edge 9
        push(3'b001, 4'hA, 4'h6);
        repeat (2) @(negedge clk);
        check_val("xor_preload_op", 32'(alu_opcode), 32'd0);
        @(negedge clk);
        check_val("xor_load_op", 32'(alu_opcode), 32'd1);
        check_val("xor_load_a", 32'(alu_a), 32'hA);
        check_val("xor_load_b", 32'(alu_b), 32'h6);
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ok &= (alu_a == 4'hA) && (alu_b == 4'h6) && (alu_opcode == 3'b001) && !io.out_valid;
        end
        check_val("xor_hold", 32'(ok), 32'd1);
        @(negedge clk);
        check_val("xor_valid_at_5", 32'(io.out_valid), 32'd1);
        wait_out("xor", 4'hC, 3'b010, 3'b001, t_seen);
        check_val("xor_alu_idle", 32'(alu_opcode), 32'd0);
        @(negedge clk);
        check_val("xor_drained", 32'(io.out_valid), 32'd0);

        // NAND all-ones, then ADD with carry-out; both within the latency bound
        push(3'b011, 4'hF, 4'hF);
        t_push = cyc_cnt;
        wait_out("nand", 4'h0, 3'b001, 3'b011, t_seen);
        check_val("nand_latency_ok", 32'(t_seen - t_push <= 10), 32'd1);
        @(negedge clk);
        push(3'b100, 4'h9, 4'h8);
        t_push = cyc_cnt;
        wait_out("add", 4'h1, 3'b100, 3'b100, t_seen);
        check_val("add_latency_ok", 32'(t_seen - t_push <= 10), 32'd1);
        @(negedge clk);

        // Fill: first push on a ph-3 edge so four pushes land before the first load
        wait_idle(2'd3);
        for (int i = 0; i < 4; i++) push(fill_v[i].op, fill_v[i].a, fill_v[i].b);
        check_val("fill_full_ready", 32'(io.in_ready), 32'd0);
        check_val("fill_full_count", 32'(count), 32'd4);
        push(fill_v[4].op, fill_v[4].a, fill_v[4].b);
        t_prev = 0;
        for (int i = 0; i < 5; i++) begin
            wait_out($sformatf("fill%0d", i), fill_v[i].c, fill_v[i].f, fill_v[i].op, t_seen);
            if (i > 0) check_val($sformatf("fill%0d_spacing", i), 32'(t_seen - t_prev), 32'd8);
            t_prev = t_seen;
            @(negedge clk);
        end
        check_val("fill_max_count", 32'(max_count), 32'd4);

        // Backpressure: AND result held, SUB retried, then drain+capture on one edge
        wait_idle(2'd0);
        io.out_ready = 1'b0;
        push(3'b010, 4'hC, 4'h6);
        push(3'b101, 4'h3, 4'h5);
        wait_out("bp_first", 4'h4, 3'b000, 3'b010, t_seen);
        ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            ok &= io.out_valid && (io.out_c == 4'h4) && (io.out_opcode == 3'b010);
        end
        check_val("bp_held", 32'(ok), 32'd1);
        check_val("bp_run_op", 32'(alu_opcode), 32'h5);
        check_val("bp_run_a", 32'(alu_a), 32'h3);
        check_val("bp_run_b", 32'(alu_b), 32'h5);
        check_val("bp_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4 && tb_ph != 2'd0; i++) @(negedge clk);
        io.out_ready = 1'b1;
        @(negedge clk);
        check_val("bp_same_edge_valid", 32'(io.out_valid), 32'd1);
        check_val("bp_second_c", 32'(io.out_c), 32'hE);
        check_val("bp_second_flags", 32'(io.out_flags), 32'h6);
        check_val("bp_second_op", 32'(io.out_opcode), 32'h5);
        @(negedge clk);
        check_val("bp_drained", 32'(io.out_valid), 32'd0);

        // Async reset mid-RUN with a held result and a queued entry
        wait_idle(2'd0);
        io.out_ready = 1'b0;
        push(3'b111, 4'h7, 4'h2);
        push(3'b001, 4'h1, 4'h1);
        push(3'b110, 4'h2, 4'h2);
        wait_out("rst_first", 4'h7, 3'b000, 3'b111, t_seen);
        for (int i = 0; i < 10 && alu_opcode != 3'b001; i++) @(negedge clk);
        check_val("rst_pre_run", 32'(alu_opcode), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_out_valid", 32'(io.out_valid), 32'd0);
        check_val("arst_count", 32'(count), 32'd0);
        check_val("arst_alu_opcode", 32'(alu_opcode), 32'd0);
        check_val("arst_alu_a", 32'(alu_a), 32'd0);
        check_val("arst_out_c", 32'(io.out_c), 32'd0);
        check_val("arst_busy", 32'(busy), 32'd0);
        check_val("arst_in_ready", 32'(io.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        io.out_ready = 1'b1;

        // Opcode 000 passes through unchanged after reset
        push(3'b000, 4'h5, 4'h3);
        t_push = cyc_cnt;
        wait_out("zero_op", 4'h0, 3'b001, 3'b000, t_seen);
        check_val("zero_op_latency_ok", 32'(t_seen - t_push <= 10), 32'd1);
        @(negedge clk);
        check_val("final_valid", 32'(io.out_valid), 32'd0);
        check_val("final_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
